// File: rtl/load_store_unit_pkg.sv
// Shared operation types for the load/store unit.
// Holds the command, access-type and atomic-op encodings used by the execute
// stage, the LSU state enum, and small helpers for access sizing, alignment
// checking and byte-strobe generation on the 64-bit memory port.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    CmdNone             = 3'd0,
    CmdLoad             = 3'd1,
    CmdStore            = 3'd2,
    CmdInvalidate       = 3'd3,
    CmdLoadReserved     = 3'd4,
    CmdStoreConditional = 3'd5,
    CmdAtomicMemOp      = 3'd6
  } LoadStoreUnitCommand;

  typedef enum logic [2:0] {
    TypeByte             = 3'd0,
    TypeHalfWord         = 3'd1,
    TypeWord             = 3'd2,
    TypeDoubleWord       = 3'd3,
    TypeUnsignedByte     = 3'd4,
    TypeUnsignedHalfWord = 3'd5
  } LoadStoreType;

  typedef enum logic [3:0] {
    AmoSwap = 4'd0,
    AmoAdd  = 4'd1,
    AmoXor  = 4'd2,
    AmoAnd  = 4'd3,
    AmoOr   = 4'd4,
    AmoMin  = 4'd5,
    AmoMax  = 4'd6,
    AmoMinu = 4'd7,
    AmoMaxu = 4'd8,
    AmoLr   = 4'd9,
    AmoSc   = 4'd10
  } AtomicType;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdReq  = 3'd1,
    StRdWait = 3'd2,
    StWrReq  = 3'd3,
    StWrWait = 3'd4,
    StDone   = 3'd5
  } LsuState;

  // log2 of the access size in bytes. LR/SC/AMO are always word accesses,
  // whatever load_store_type the execute stage happens to present.
  function automatic logic [1:0] sizeOf(LoadStoreUnitCommand cmd, LoadStoreType t);
    logic [1:0] size;
    if (cmd == CmdLoadReserved || cmd == CmdStoreConditional || cmd == CmdAtomicMemOp) begin
      size = 2'd2;
    end else begin
      case (t)
        TypeByte, TypeUnsignedByte:         size = 2'd0;
        TypeHalfWord, TypeUnsignedHalfWord: size = 2'd1;
        TypeWord:                           size = 2'd2;
        TypeDoubleWord:                     size = 2'd3;
        default:                            size = 2'd0;
      endcase
    end
    return size;
  endfunction

  // Invalidate (and None) never touch memory, so they can never fault.
  function automatic logic isMisaligned(LoadStoreUnitCommand cmd, LoadStoreType t,
                                        logic [2:0] low);
    logic mis;
    if (cmd == CmdNone || cmd == CmdInvalidate) begin
      mis = 1'b0;
    end else begin
      case (sizeOf(cmd, t))
        2'd0:    mis = 1'b0;
        2'd1:    mis = low[0];
        2'd2:    mis = |low[1:0];
        default: mis = |low;
      endcase
    end
    return mis;
  endfunction

  function automatic logic [7:0] wstrbOf(logic [1:0] size, logic [2:0] lane);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/load_store_unit_amo.sv
// Combinational 32-bit ALU for word atomic memory operations.
// Ports:
//   atomicType  in  4   AtomicType encoding
//   old         in  32  value read from memory
//   src         in  32  register operand
//   newValue    out 32  value to write back
module amo_alu
  import load_store_unit_pkg::*;
(
  input  logic [3:0]  atomicType,
  input  logic [31:0] old,
  input  logic [31:0] src,
  output logic [31:0] newValue
);

  AtomicType op;
  logic signed [31:0] oldS;
  logic signed [31:0] srcS;

  assign op   = AtomicType'(atomicType);
  assign oldS = old;
  assign srcS = src;

  always_comb begin
    newValue = old;
    case (op)
      AmoSwap: newValue = src;
      AmoAdd:  newValue = old + src;
      AmoXor:  newValue = old ^ src;
      AmoAnd:  newValue = old & src;
      AmoOr:   newValue = old | src;
      AmoMin:  newValue = (oldS < srcS) ? old : src;
      AmoMax:  newValue = (oldS > srcS) ? old : src;
      AmoMinu: newValue = (old < src) ? old : src;
      AmoMaxu: newValue = (old > src) ? old : src;
      default: newValue = old;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: responds to a held execute-stage request and runs the
// needed transaction(s) on a 64-bit request/response data-memory port.
// Supports loads, stores, LR/SC with a single reservation, word AMOs
// (read-modify-write) and invalidate.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              request, held until done
//   command             LoadStoreUnitCommand
//   load_store_type     LoadStoreType
//   atomic_type         AtomicType
//   addr                byte address
//   store_value         right-aligned store data / AMO operand
//   done                one-cycle completion pulse
//   result              load / old-AMO / SC status, valid with done
//   fault               misaligned access, valid with done
//   mem_req_valid/ready request handshake
//   mem_addr            doubleword-aligned address
//   mem_we, mem_wstrb   write enable and byte enables
//   mem_wdata           store data shifted into its byte lane
//   mem_rsp_valid       read data or write acknowledge
//   mem_rdata           read data
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [2:0]            command,
  input  logic [2:0]            load_store_type,
  input  logic [3:0]            atomic_type,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_value,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  fault,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  LsuState             state;
  LoadStoreUnitCommand cmdIn;
  LoadStoreType        typeIn;
  LoadStoreUnitCommand cmdQ;
  LoadStoreType        typeQ;
  logic [3:0]          atomQ;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [31:0]         srcQ;

  logic                  resValid;
  logic [ADDR_WIDTH-4:0] resGranule;
  logic                  resHit;

  logic [DATA_WIDTH-1:0] laneData;
  logic [DATA_WIDTH-1:0] loadValue;
  logic [DATA_WIDTH-1:0] oldWordExt;
  logic [31:0]           amoNew;

  assign cmdIn  = LoadStoreUnitCommand'(command);
  assign typeIn = LoadStoreType'(load_store_type);
  assign resHit = resValid && (resGranule == addr[ADDR_WIDTH-1:3]);

  // Read data right-aligned to the addressed byte lane.
  assign laneData   = mem_rdata >> {addrQ[2:0], 3'b000};
  assign oldWordExt = {{32{laneData[31]}}, laneData[31:0]};

  amo_alu uAmo (
    .atomicType(atomQ),
    .old       (laneData[31:0]),
    .src       (srcQ),
    .newValue  (amoNew)
  );

  // Word loads NaN-box the upper half so FLW can share this path.
  always_comb begin
    loadValue = '0;
    case (typeQ)
      TypeByte:             loadValue = {32'b0, {24{laneData[7]}}, laneData[7:0]};
      TypeUnsignedByte:     loadValue = {56'b0, laneData[7:0]};
      TypeHalfWord:         loadValue = {32'b0, {16{laneData[15]}}, laneData[15:0]};
      TypeUnsignedHalfWord: loadValue = {48'b0, laneData[15:0]};
      TypeWord:             loadValue = {32'hFFFF_FFFF, laneData[31:0]};
      TypeDoubleWord:       loadValue = laneData;
      default:              loadValue = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      done          <= 1'b0;
      fault         <= 1'b0;
      result        <= '0;
      mem_req_valid <= 1'b0;
      resValid      <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        StIdle: begin
          if (enable && cmdIn != CmdNone) begin
            cmdQ      <= cmdIn;
            typeQ     <= typeIn;
            atomQ     <= atomic_type;
            addrQ     <= addr;
            srcQ      <= store_value[31:0];
            result    <= '0;
            mem_addr  <= {addr[ADDR_WIDTH-1:3], 3'b000};
            mem_wstrb <= wstrbOf(sizeOf(cmdIn, typeIn), addr[2:0]);
            mem_wdata <= store_value << {addr[2:0], 3'b000};
            // Every SC consumes the reservation, even a faulting one.
            if (cmdIn == CmdStoreConditional) resValid <= 1'b0;
            if (isMisaligned(cmdIn, typeIn, addr[2:0])) begin
              state <= StDone;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              case (cmdIn)
                CmdLoad, CmdLoadReserved, CmdAtomicMemOp: begin
                  state         <= StRdReq;
                  mem_we        <= 1'b0;
                  mem_req_valid <= 1'b1;
                end
                CmdStore: begin
                  state         <= StWrReq;
                  mem_we        <= 1'b1;
                  mem_req_valid <= 1'b1;
                  if (resHit) resValid <= 1'b0;
                end
                CmdStoreConditional: begin
                  if (resHit) begin
                    state         <= StWrReq;
                    mem_we        <= 1'b1;
                    mem_req_valid <= 1'b1;
                  end else begin
                    state  <= StDone;
                    done   <= 1'b1;
                    result <= 64'd1;
                  end
                end
                default: begin
                  state <= StDone;
                  done  <= 1'b1;
                end
              endcase
            end
          end
        end
        StRdReq: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= StRdWait;
          end
        end
        StRdWait: begin
          if (mem_rsp_valid) begin
            if (cmdQ == CmdAtomicMemOp) begin
              // Strobes were already set for a word at this lane.
              result        <= oldWordExt;
              mem_wdata     <= {32'b0, amoNew} << {addrQ[2:0], 3'b000};
              mem_we        <= 1'b1;
              mem_req_valid <= 1'b1;
              state         <= StWrReq;
            end else begin
              if (cmdQ == CmdLoadReserved) begin
                result     <= oldWordExt;
                resValid   <= 1'b1;
                resGranule <= addrQ[ADDR_WIDTH-1:3];
              end else begin
                result <= loadValue;
              end
              state <= StDone;
              done  <= 1'b1;
            end
          end
        end
        StWrReq: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= StWrWait;
          end
        end
        StWrWait: begin
          if (mem_rsp_valid) begin
            state <= StDone;
            done  <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state         <= StIdle;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  command;
  logic [2:0]  load_store_type;
  logic [3:0]  atomic_type;
  logic [31:0] addr;
  logic [63:0] store_value;
  logic        done;
  logic [63:0] result;
  logic        fault;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .command(command),
    .load_store_type(load_store_type), .atomic_type(atomic_type),
    .addr(addr), .store_value(store_value), .done(done), .result(result),
    .fault(fault), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  // Stimulus helpers (no checking inside); all called at a negedge.
  task automatic issue(input logic [2:0] c, input logic [2:0] t, input logic [3:0] at,
                       input logic [31:0] a, input logic [63:0] v);
    enable = 1'b1; command = c; load_store_type = t; atomic_type = at;
    addr = a; store_value = v;
  endtask

  task automatic release_req();
    enable = 1'b0; command = CmdNone;
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) begin
        seen = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Request is accepted at the next edge; respond one cycle later.
  task automatic respond(input logic [63:0] d);
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rdata = d;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b want 0", fault); end
    vectors++; if (result !== 64'd0) begin miscompares++; $display("FAIL reset_result got %h want 0", result); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_reqvalid got %b want 0", mem_req_valid); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_byte();
    bit seen;
    issue(CmdLoad, TypeByte, 4'd0, 32'h103, 64'd0);
    wait_req(seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL lb_req_timeout got none want request"); end
    vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL lb_addr got %h want 00000100", mem_addr); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL lb_we got %b want 0", mem_we); end
    respond(64'h0000_0000_8000_0000);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL lb_done got %b want 1", done); end
    vectors++; if (result !== 64'h0000_0000_FFFF_FF80) begin miscompares++; $display("FAIL lb_result got %h want 00000000ffffff80", result); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL lb_second_req got %b want 0", mem_req_valid); end
    release_req();
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL lb_done_pulse got %b want 0", done); end
  endtask

  task automatic test_load_extend();
    bit seen;
    issue(CmdLoad, TypeWord, 4'd0, 32'h4, 64'd0);
    wait_req(seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL lw_req_timeout got none want request"); end
    respond(64'h1234_5678_0000_0000);
    vectors++; if (result !== 64'hFFFF_FFFF_1234_5678) begin miscompares++; $display("FAIL lw_nanbox got %h want ffffffff12345678", result); end
    release_req();
    @(negedge clk);
    issue(CmdLoad, TypeUnsignedByte, 4'd0, 32'h5, 64'd0);
    wait_req(seen);
    respond(64'h0000_8000_0000_0000);
    vectors++; if (result !== 64'h80) begin miscompares++; $display("FAIL lbu_result got %h want 80", result); end
    release_req();
    @(negedge clk);
  endtask

  task automatic test_store_half();
    bit seen;
    issue(CmdStore, TypeHalfWord, 4'd0, 32'h206, 64'hBEEF);
    wait_req(seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL sh_req_timeout got none want request"); end
    vectors++; if (mem_addr !== 32'h200) begin miscompares++; $display("FAIL sh_addr got %h want 00000200", mem_addr); end
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL sh_we got %b want 1", mem_we); end
    vectors++; if (mem_wstrb !== 8'hC0) begin miscompares++; $display("FAIL sh_wstrb got %h want c0", mem_wstrb); end
    vectors++; if (mem_wdata !== 64'hBEEF_0000_0000_0000) begin miscompares++; $display("FAIL sh_wdata got %h want beef000000000000", mem_wdata); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL sh_early_done got %b want 0", done); end
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL sh_done got %b want 1", done); end
    release_req();
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    issue(CmdLoad, TypeWord, 4'd0, 32'h2, 64'd0);
    @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL lw_mis_done got %b want 1", done); end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL lw_mis_fault got %b want 1", fault); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL lw_mis_req got %b want 0", mem_req_valid); end
    release_req();
    @(negedge clk);
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL lw_mis_fault_clear got %b want 0", fault); end
  endtask

  task automatic test_lr_sc();
    bit seen;
    issue(CmdLoadReserved, TypeWord, AmoLr, 32'h40, 64'd0);
    wait_req(seen);
    respond(64'h0000_0000_8000_0001);
    vectors++; if (result !== 64'hFFFF_FFFF_8000_0001) begin miscompares++; $display("FAIL lr_result got %h want ffffffff80000001", result); end
    release_req();
    @(negedge clk);
    issue(CmdStoreConditional, TypeWord, AmoSc, 32'h40, 64'h1234_5678);
    wait_req(seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL sc_req_timeout got none want request"); end
    vectors++; if (mem_we !== 1'b1 || mem_wstrb !== 8'h0F) begin miscompares++; $display("FAIL sc_write got we=%b strb=%h want we=1 strb=0f", mem_we, mem_wstrb); end
    vectors++; if (mem_wdata[31:0] !== 32'h1234_5678) begin miscompares++; $display("FAIL sc_wdata got %h want 12345678", mem_wdata[31:0]); end
    respond(64'd0);
    vectors++; if (done !== 1'b1 || result !== 64'd0) begin miscompares++; $display("FAIL sc_ok got done=%b result=%h want done=1 result=0", done, result); end
    release_req();
    @(negedge clk);
    issue(CmdStoreConditional, TypeWord, AmoSc, 32'h40, 64'h1);
    @(negedge clk);
    vectors++; if (done !== 1'b1 || result !== 64'd1) begin miscompares++; $display("FAIL sc_fail got done=%b result=%h want done=1 result=1", done, result); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL sc_fail_req got %b want 0", mem_req_valid); end
    release_req();
    @(negedge clk);
    // A plain store to the reserved granule kills the reservation.
    issue(CmdLoadReserved, TypeWord, AmoLr, 32'h48, 64'd0);
    wait_req(seen);
    respond(64'd0);
    release_req();
    @(negedge clk);
    issue(CmdStore, TypeDoubleWord, 4'd0, 32'h48, 64'h55);
    wait_req(seen);
    respond(64'd0);
    release_req();
    @(negedge clk);
    issue(CmdStoreConditional, TypeWord, AmoSc, 32'h4C, 64'h1);
    @(negedge clk);
    vectors++; if (result !== 64'd1 || mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL sc_after_store got result=%h req=%b want result=1 req=0", result, mem_req_valid); end
    release_req();
    @(negedge clk);
  endtask

  task automatic test_amo();
    bit seen;
    issue(CmdAtomicMemOp, TypeWord, AmoAdd, 32'hC, 64'd7);
    wait_req(seen);
    vectors++; if (mem_we !== 1'b0 || mem_addr !== 32'h8) begin miscompares++; $display("FAIL amo_read got we=%b addr=%h want we=0 addr=8", mem_we, mem_addr); end
    respond(64'h0000_0005_0000_0000);
    wait_req(seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL amo_wr_timeout got none want request"); end
    vectors++; if (mem_we !== 1'b1 || mem_wstrb !== 8'hF0) begin miscompares++; $display("FAIL amo_write got we=%b strb=%h want we=1 strb=f0", mem_we, mem_wstrb); end
    vectors++; if (mem_wdata !== 64'h0000_000C_0000_0000) begin miscompares++; $display("FAIL amo_wdata got %h want 0000000c00000000", mem_wdata); end
    respond(64'd0);
    vectors++; if (done !== 1'b1 || result !== 64'd5) begin miscompares++; $display("FAIL amo_result got done=%b result=%h want done=1 result=5", done, result); end
    release_req();
    @(negedge clk);
    issue(CmdAtomicMemOp, TypeWord, AmoMin, 32'h10, 64'hFFFF_FFFE);
    wait_req(seen);
    respond(64'h0000_0000_0000_0003);
    wait_req(seen);
    vectors++; if (mem_wdata !== 64'h0000_0000_FFFF_FFFE) begin miscompares++; $display("FAIL amomin_wdata got %h want 00000000fffffffe", mem_wdata); end
    respond(64'd0);
    vectors++; if (result !== 64'd3) begin miscompares++; $display("FAIL amomin_result got %h want 3", result); end
    release_req();
    @(negedge clk);
  endtask

  task automatic test_stall();
    bit seen;
    mem_req_ready = 1'b0;
    issue(CmdLoad, TypeDoubleWord, 4'd0, 32'h18, 64'd0);
    wait_req(seen);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h18 || mem_we !== 1'b0) begin miscompares++; $display("FAIL stall_hold got valid=%b addr=%h we=%b want 1 18 0", mem_req_valid, mem_addr, mem_we); end
    end
    mem_req_ready = 1'b1;
    respond(64'h1122_3344_5566_7788);
    vectors++; if (result !== 64'h1122_3344_5566_7788) begin miscompares++; $display("FAIL ld_result got %h want 1122334455667788", result); end
    release_req();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    issue(CmdLoad, TypeWord, 4'd0, 32'h20, 64'd0);
    wait_req(seen);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    release_req();
    vectors++; if (done !== 1'b0 || mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid got done=%b req=%b want 0 0", done, mem_req_valid); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_late_done got %b want 0", done); end
    issue(CmdLoad, TypeByte, 4'd0, 32'h21, 64'd0);
    wait_req(seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL rst_next_timeout got none want request"); end
    respond(64'h0000_0000_0000_7F00);
    vectors++; if (done !== 1'b1 || result !== 64'h7F) begin miscompares++; $display("FAIL rst_next got done=%b result=%h want 1 7f", done, result); end
    release_req();
    @(negedge clk);
    // Reset must also drop a live reservation.
    issue(CmdLoadReserved, TypeWord, AmoLr, 32'h60, 64'd0);
    wait_req(seen);
    respond(64'd0);
    release_req();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(CmdStoreConditional, TypeWord, AmoSc, 32'h60, 64'd0);
    @(negedge clk);
    vectors++; if (result !== 64'd1 || mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resv got result=%h req=%b want 1 0", result, mem_req_valid); end
    release_req();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(CmdLoad, TypeHalfWord, 4'd0, 32'h1, 64'd0);
    @(negedge clk);
    vectors++; if (done !== 1'b1 || fault !== 1'b1) begin miscompares++; $display("FAIL b2b_first got done=%b fault=%b want 1 1", done, fault); end
    issue(CmdInvalidate, TypeWord, 4'd0, 32'h80, 64'd0);
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_gap got %b want 0", done); end
    @(negedge clk);
    vectors++; if (done !== 1'b1 || fault !== 1'b0 || result !== 64'd0) begin miscompares++; $display("FAIL b2b_inval got done=%b fault=%b result=%h want 1 0 0", done, fault, result); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_inval_req got %b want 0", mem_req_valid); end
    release_req();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; command = CmdNone; load_store_type = '0;
    atomic_type = '0; addr = '0; store_value = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = '0;
    test_reset();
    test_load_byte();
    test_load_extend();
    test_store_half();
    test_misaligned();
    test_lr_sc();
    test_amo();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
